// File: rtl/gf180mcu_fd_io__seg_pwrseq.sv
// Pad-ring segment power sequencer: qualifies supply-good, settles, then releases pad groups in order.
// Optional REQ-to-ACK watchdog enabled by defining GF180MCU_FD_IO__SEG_PWRSEQ_WDOG_EN.
module gf180mcu_fd_io__seg_pwrseq #(
  parameter int DEB_CYC    = 4,
  parameter int SETTLE_CYC = 64,
  parameter int NSEG       = 4,
  parameter int STEP_CYC   = 8,
  parameter int TMO_CYC    = 255,
  parameter int CW         = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            PG,
  input  logic            REQ,
  output logic            ACK,
  output logic [NSEG-1:0] IE_EN,
  output logic [NSEG-1:0] OE_EN,
  output logic            FAULT,
  output logic [2:0]      STATE
);

  typedef enum logic [2:0] {
    S_OFF    = 3'd0,
    S_DEB    = 3'd1,
    S_SETTLE = 3'd2,
    S_RAMP   = 3'd3,
    S_ON     = 3'd4,
    S_DOWN   = 3'd5,
    S_FLT    = 3'd6
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NSEG-1:0] en_q, en_d;
  logic            pg_s1, pg_s;
  logic            wd_trip;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pg_s1 <= 1'b0;
      pg_s  <= 1'b0;
    end else begin
      pg_s1 <= PG;
      pg_s  <= pg_s1;
    end
  end

`ifdef GF180MCU_FD_IO__SEG_PWRSEQ_WDOG_EN
  logic [CW-1:0] wd_q, wd_d;

  always_comb begin
    wd_d    = wd_q;
    wd_trip = 1'b0;
    if (!REQ || state_q == S_ON) begin
      wd_d = '0;
    end else if (state_q != S_FLT) begin
      wd_trip = (wd_q == CW'(TMO_CYC - 1));
      if (wd_q != CW'(TMO_CYC))
        wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) wd_q <= '0;
    else     wd_q <= wd_d;
  end
`else
  logic tmo_unused;
  assign tmo_unused = ^CW'(TMO_CYC);
  assign wd_trip    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    en_d    = en_q;
    unique case (state_q)
      S_OFF: begin
        cnt_d = '0;
        if (REQ && pg_s) state_d = S_DEB;
      end
      S_DEB: begin
        if (!pg_s || !REQ)                     state_d = S_OFF;
        else if (cnt_q == CW'(DEB_CYC - 1))    state_d = S_SETTLE;
      end
      S_SETTLE: begin
        if (!pg_s)      state_d = S_FLT;
        else if (!REQ)  state_d = S_OFF;
        else if (cnt_q == CW'(SETTLE_CYC - 1)) begin
          state_d = S_RAMP;
          en_d    = NSEG'(1);
        end
      end
      S_RAMP: begin
        if (!pg_s) state_d = S_FLT;
        else if (!REQ) begin
          state_d = S_DOWN;
          en_d    = en_q >> 1;
        end else if (cnt_q == CW'(STEP_CYC - 1)) begin
          // Step timer restarts within RAMP; the top group being set means the ramp is complete.
          if (en_q[NSEG-1]) state_d = S_ON;
          else begin
            en_d  = (en_q << 1) | NSEG'(1);
            cnt_d = '0;
          end
        end
      end
      S_ON: begin
        if (!pg_s) state_d = S_FLT;
        else if (!REQ) begin
          state_d = S_DOWN;
          en_d    = en_q >> 1;
        end
      end
      S_DOWN: begin
        if (!pg_s)             state_d = S_FLT;
        else if (en_q == '0)   state_d = S_OFF;
        else if (cnt_q == CW'(STEP_CYC - 1)) begin
          en_d  = en_q >> 1;
          cnt_d = '0;
        end
      end
      S_FLT: begin
        if (!REQ) state_d = S_OFF;
      end
      default: state_d = S_OFF;
    endcase
    if (wd_trip)            state_d = S_FLT;
    if (state_d != state_q) cnt_d   = '0;
    if (state_d == S_FLT)   en_d    = '0;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_OFF;
      cnt_q   <= '0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      en_q    <= en_d;
    end
  end

  assign ACK   = (state_q == S_ON);
  assign FAULT = (state_q == S_FLT);
  assign STATE = state_q;
  assign IE_EN = en_q;
  assign OE_EN = en_q;

endmodule

// File: tb/tb_gf180mcu_fd_io__seg_pwrseq.sv
// Directed table-driven bench for the segment power sequencer, plus a short watchdog sequence.
module tb_gf180mcu_fd_io__seg_pwrseq;

  logic       CLK = 1'b0;
  logic       rst, pg, req;
  logic       ack, fault;
  logic [3:0] ie_en, oe_en;
  logic [2:0] state;

  logic       wrst, wreq;
  logic       wpg = 1'b0;
  logic       wack, wfault;
  logic [3:0] wie, woe;
  logic [2:0] wstate;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  gf180mcu_fd_io__seg_pwrseq dut (
    .CLK(CLK), .RST(rst), .PG(pg), .REQ(req),
    .ACK(ack), .IE_EN(ie_en), .OE_EN(oe_en), .FAULT(fault), .STATE(state)
  );

  gf180mcu_fd_io__seg_pwrseq #(.TMO_CYC(20)) u_wd (
    .CLK(CLK), .RST(wrst), .PG(wpg), .REQ(wreq),
    .ACK(wack), .IE_EN(wie), .OE_EN(woe), .FAULT(wfault), .STATE(wstate)
  );

  typedef struct {
    logic       rst, pg, req;
    int         n;
    logic [2:0] st;
    logic [3:0] en;
    logic       ack, fault;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic p, input logic q, input int n,
                     input logic [2:0] st, input logic [3:0] en, input logic a, input logic f);
    vec_t v;
    v.rst = r; v.pg = p; v.req = q; v.n = n;
    v.st = st; v.en = en; v.ack = a; v.fault = f;
    vecs.push_back(v);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string name, input int idx, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got %0h, expected %0h", name, idx, got, exp);
    end
  endtask

  initial begin
    rst = 1'b1; pg = 1'b0; req = 1'b0;
    wrst = 1'b1; wreq = 1'b0;

    // reset
    add(1,0,0,  2, 0, 4'h0, 0, 0);
    // power-up latency from a settled PG
    add(0,1,0, 10, 0, 4'h0, 0, 0);
    add(0,1,1,  1, 1, 4'h0, 0, 0);
    add(0,1,1,  3, 1, 4'h0, 0, 0);
    add(0,1,1,  1, 2, 4'h0, 0, 0);
    add(0,1,1, 63, 2, 4'h0, 0, 0);
    add(0,1,1,  1, 3, 4'h1, 0, 0);
    add(0,1,1,  8, 3, 4'h3, 0, 0);
    add(0,1,1, 23, 3, 4'hF, 0, 0);
    add(0,1,1,  1, 4, 4'hF, 1, 0);
    // power-down order
    add(0,1,0,  1, 5, 4'h7, 0, 0);
    add(0,1,0,  7, 5, 4'h7, 0, 0);
    add(0,1,0,  1, 5, 4'h3, 0, 0);
    add(0,1,0,  8, 5, 4'h1, 0, 0);
    add(0,1,0,  8, 5, 4'h0, 0, 0);
    add(0,1,0,  1, 0, 4'h0, 0, 0);
    // supply loss while ON
    add(0,1,1,101, 4, 4'hF, 1, 0);
    add(0,0,1,  2, 4, 4'hF, 1, 0);
    add(0,0,1,  1, 6, 4'h0, 0, 1);
    add(0,0,1,  5, 6, 4'h0, 0, 1);
    add(0,0,0,  1, 0, 4'h0, 0, 0);
    // PG glitch during debounce
    add(0,1,0,  3, 0, 4'h0, 0, 0);
    add(0,1,1,  1, 1, 4'h0, 0, 0);
    add(0,1,1,  1, 1, 4'h0, 0, 0);
    add(0,0,1,  1, 1, 4'h0, 0, 0);
    add(0,1,1,  1, 1, 4'h0, 0, 0);
    add(0,1,1,  1, 0, 4'h0, 0, 0);
    add(0,1,1,  1, 1, 4'h0, 0, 0);
    add(0,1,1, 99, 3, 4'hF, 0, 0);
    add(0,1,1,  1, 4, 4'hF, 1, 0);
    // asynchronous reset mid-ramp (n=0: no clock edge before the check)
    add(1,1,1,  0, 0, 4'h0, 0, 0);
    add(0,1,1,  2, 0, 4'h0, 0, 0);
    add(0,1,1,  1, 1, 4'h0, 0, 0);
    add(0,1,1, 68, 3, 4'h1, 0, 0);
    add(0,1,1,  8, 3, 4'h3, 0, 0);
    add(1,1,1,  0, 0, 4'h0, 0, 0);
    add(1,1,1,  2, 0, 4'h0, 0, 0);
    add(0,1,1,  2, 0, 4'h0, 0, 0);
    add(0,1,1,  1, 1, 4'h0, 0, 0);
    add(0,1,1,100, 4, 4'hF, 1, 0);

    foreach (vecs[i]) begin
      rst = vecs[i].rst; pg = vecs[i].pg; req = vecs[i].req;
      if (i == 0) wrst = 1'b1;
      if (vecs[i].n == 0) #1;
      else tick(vecs[i].n);
      if (i == 0) wrst = 1'b0;
      chk("state", i, {1'b0, state}, {1'b0, vecs[i].st});
      chk("ie_en", i, ie_en, vecs[i].en);
      chk("oe_en", i, oe_en, vecs[i].en);
      chk("ack",   i, {3'b0, ack},   {3'b0, vecs[i].ack});
      chk("fault", i, {3'b0, fault}, {3'b0, vecs[i].fault});
    end

    // watchdog instance: PG never rises, REQ held high
    wreq = 1'b1;
    tick(19);
    chk("wd_state_19", 0, {1'b0, wstate}, 4'h0);
    chk("wd_fault_19", 0, {3'b0, wfault}, 4'h0);
    tick(1);
`ifdef GF180MCU_FD_IO__SEG_PWRSEQ_WDOG_EN
    chk("wd_state_20", 0, {1'b0, wstate}, 4'h6);
    chk("wd_fault_20", 0, {3'b0, wfault}, 4'h1);
    chk("wd_en_20",    0, wie, 4'h0);
`else
    chk("wd_state_20", 0, {1'b0, wstate}, 4'h0);
    chk("wd_fault_20", 0, {3'b0, wfault}, 4'h0);
    chk("wd_en_20",    0, wie, 4'h0);
`endif
    tick(10);
`ifdef GF180MCU_FD_IO__SEG_PWRSEQ_WDOG_EN
    chk("wd_fault_hold", 0, {3'b0, wfault}, 4'h1);
`else
    chk("wd_fault_hold", 0, {3'b0, wfault}, 4'h0);
`endif
    wreq = 1'b0;
    tick(1);
    chk("wd_state_clr", 0, {1'b0, wstate}, 4'h0);
    chk("wd_fault_clr", 0, {3'b0, wfault}, 4'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
